// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, FSM encoding and synchronizer event payload for the SPI flash responder.
package spi_flash_responder_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;

    localparam int unsigned CMD_BITS  = 8;
    localparam int unsigned ADDR_BITS = 24;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        FETCH,
        DATA,
        ID,
        STATUS,
        IGNORE
    } state_e;

    // Synchronized SPI pins plus single-cycle edge events, all aligned to the same clk.
    typedef struct packed {
        logic ss_level;
        logic mosi;
        logic sck_rise;
        logic sck_fall;
        logic ss_fall;
        logic ss_rise;
    } spi_evt_t;

    // Deselected bus: SS high, no edges.
    localparam spi_evt_t EVT_IDLE = spi_evt_t'(6'b10_0000);

    // Map a received opcode to the state that services it.
    function automatic state_e opcode_target(input logic [7:0] op);
        case (op)
            OP_READ: opcode_target = ADDR;
            OP_RDID: opcode_target = ID;
            OP_RDSR: opcode_target = STATUS;
            default: opcode_target = IGNORE;
        endcase
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizers for SCK/SS/MOSI with registered SCK and SS edge pulses.
module spi_slave_sync
    import spi_flash_responder_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     spi_sck,
    input  logic     spi_ss,
    input  logic     spi_mosi,
    output spi_evt_t evt
);

    // Bit order {ss, sck, mosi}; SS resets high so a held-low SS never fakes a select.
    localparam logic [2:0] SYNC_IDLE = 3'b100;

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] sync3;

    // Synchronize the pins and derive edges from the second stage against its delayed copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
            sync3 <= SYNC_IDLE;
            evt   <= EVT_IDLE;
        end else begin
            sync1        <= {spi_ss, spi_sck, spi_mosi};
            sync2        <= sync1;
            sync3        <= sync2;
            evt.ss_level <= sync2[2];
            evt.mosi     <= sync2[0];
            evt.sck_rise <=  sync2[1] & ~sync3[1];
            evt.sck_fall <= ~sync2[1] &  sync3[1];
            evt.ss_fall  <= ~sync2[2] &  sync3[2];
            evt.ss_rise  <=  sync2[2] & ~sync3[2];
        end
    end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave answering READ / RDID / RDSR from a synchronous byte-wide memory.
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 17,
    parameter logic [23:0] JEDEC_ID = 24'hEF4017
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic              active,
    output logic              cmd_error
);

    spi_evt_t               evt;
    state_e                 state;
    state_e                 state_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic [ADDR_BITS-2:0]   in_shift;
    logic [ADDR_BITS-1:0]   in_word;
    logic                   last_bit;
    logic                   deselect;
    logic [7:0]             out_shift;
    logic [7:0]             next_byte;
    logic [2:0]             bits_left;
    logic [1:0]             id_idx;
    logic                   rd_pend;

    spi_slave_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .spi_sck  (spi_sck),
        .spi_ss   (spi_ss),
        .spi_mosi (spi_mosi),
        .evt      (evt)
    );

    // JEDEC ID bytes MSB first, then zeros forever.
    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a deselected bus wins over everything else.
    always_comb begin
        state_nxt = state;
        in_word   = {in_shift, evt.mosi};
        deselect  = evt.ss_level | evt.ss_rise;
        last_bit  = 1'b0;
        case (state)
            CMD:     last_bit = evt.sck_rise && (bit_cnt == CNT_W'(CMD_BITS - 1));
            ADDR:    last_bit = evt.sck_rise && (bit_cnt == CNT_W'(ADDR_BITS - 1));
            default: last_bit = 1'b0;
        endcase
        if (deselect) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (evt.ss_fall) state_nxt = CMD;
                CMD:     if (last_bit) state_nxt = opcode_target(in_word[7:0]);
                ADDR:    if (last_bit) state_nxt = FETCH;
                FETCH:   if (rd_pend) state_nxt = DATA;
                default: state_nxt = state;
            endcase
        end
    end

    // Shift-in, memory port, MISO serializer and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spi_miso  <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            active    <= 1'b0;
            cmd_error <= 1'b0;
            rd_pend   <= 1'b0;
            bit_cnt   <= '0;
            in_shift  <= '0;
            out_shift <= '0;
            next_byte <= '0;
            bits_left <= '0;
            id_idx    <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            rd_pend   <= mem_rd_en;
            active    <= (state_nxt != IDLE);
            cmd_error <= (state == CMD) && (state_nxt == IGNORE);
            if (state_nxt == IDLE) begin
                spi_miso  <= 1'b0;
                bit_cnt   <= '0;
                bits_left <= '0;
            end else begin
                case (state)
                    CMD, ADDR: begin
                        if (evt.sck_rise) begin
                            in_shift <= in_word[ADDR_BITS-2:0];
                            bit_cnt  <= last_bit ? CNT_W'(0) : bit_cnt + CNT_W'(1);
                        end
                        if (state_nxt == FETCH) begin
                            mem_addr  <= ADDR_W'(in_word);
                            mem_rd_en <= 1'b1;
                        end
                        if (state_nxt == ID) begin
                            next_byte <= id_byte(2'd0);
                            id_idx    <= 2'd1;
                        end
                        if (state_nxt == STATUS) begin
                            next_byte <= 8'h00;
                        end
                    end
                    FETCH: begin
                        if (rd_pend) next_byte <= mem_rd_data;
                    end
                    DATA, ID, STATUS: begin
                        if (state == DATA && rd_pend) next_byte <= mem_rd_data;
                        if (evt.sck_fall) begin
                            if (bits_left == 3'd0) begin
                                // Byte boundary: present the staged byte and refill the stage.
                                spi_miso  <= next_byte[7];
                                out_shift <= {next_byte[6:0], 1'b0};
                                bits_left <= 3'd7;
                                if (state == DATA) begin
                                    mem_addr  <= mem_addr + ADDR_W'(1);
                                    mem_rd_en <= 1'b1;
                                end
                                if (state == ID) begin
                                    next_byte <= id_byte(id_idx);
                                    if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                                end
                                if (state == STATUS) next_byte <= 8'h00;
                            end else begin
                                spi_miso  <= out_shift[7];
                                out_shift <= {out_shift[6:0], 1'b0};
                                bits_left <= bits_left - 3'd1;
                            end
                        end
                    end
                    IGNORE: spi_miso <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder with an in-bench flash/memory model.
module tb_spi_flash_responder;

    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned MEM_SIZE = 1 << ADDR_W;
    localparam logic [23:0] JEDEC    = 24'hEF4017;
    localparam int          HALF     = 80;

    logic              clk = 1'b0;
    logic              reset;
    logic              spi_sck;
    logic              spi_ss;
    logic              spi_mosi;
    logic              spi_miso;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rd_data = 8'h00;
    logic              active;
    logic              cmd_error;

    always #5 clk = ~clk;

    spi_flash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(JEDEC)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sck     (spi_sck),
        .spi_ss      (spi_ss),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .active      (active),
        .cmd_error   (cmd_error)
    );

    logic [7:0]        mem [MEM_SIZE];
    logic [ADDR_W-1:0] rd_log[$];
    logic [7:0]        got[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                hi_cnt  = 0;
    int                lo_cnt  = 0;
    int                err_pulses = 0;
    bit                txn_open  = 1'b0;
    bit                miso_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Synchronous memory: data one clk after the strobe; every read is logged.
    always @(posedge clk) begin
        if (reset && mem_rd_en) begin
            rd_log.push_back(mem_addr);
            mem_rd_data <= mem[mem_addr];
        end
    end

    // Track how long SS has been stable at its current level.
    always @(posedge clk) begin
        if (spi_ss) begin
            hi_cnt++;
            lo_cnt = 0;
        end else begin
            lo_cnt++;
            hi_cnt = 0;
        end
    end

    // Per-cycle compare of the bus-level rules.
    always @(negedge clk) begin
        if (reset) begin
            if (hi_cnt >= 5) begin
                chk("idle miso", spi_miso, 0);
                chk("idle active", active, 0);
                chk("idle rd_en", mem_rd_en, 0);
            end else if (txn_open && lo_cnt >= 5) begin
                chk("sel active", active, 1);
            end
            if (cmd_error) err_pulses++;
            if (txn_open && spi_miso) miso_seen = 1'b1;
        end
    end

    function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [23:0] addr,
                                              input int k);
        if (op == 8'h03) return mem[ADDR_W'(addr + 24'(k))];
        if (op == 8'h9F) return (k < 3) ? 8'(JEDEC >> (8 * (2 - k))) : 8'h00;
        return 8'h00;
    endfunction

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            spi_sck  = 1'b0;
            spi_mosi = tx[i];
            #(HALF);
            spi_sck = 1'b1;
            rx[i]   = spi_miso;
            #(HALF);
        end
    endtask

    task automatic ss_begin();
        rd_log.delete();
        got.delete();
        err_pulses = 0;
        miso_seen  = 1'b0;
        spi_ss     = 1'b0;
        txn_open   = 1'b1;
        #(HALF);
    endtask

    task automatic ss_end();
        spi_sck  = 1'b0;
        spi_ss   = 1'b1;
        txn_open = 1'b0;
        #(5 * HALF);
    endtask

    task automatic run_txn(input string tag, input logic [7:0] op, input logic [23:0] addr,
                           input int n);
        logic [7:0] rx;
        int         exp_reads;
        bit         known;
        known = (op == 8'h03) || (op == 8'h9F) || (op == 8'h05);
        ss_begin();
        spi_bits(op, 8, rx);
        if (op == 8'h03) begin
            spi_bits(addr[23:16], 8, rx);
            spi_bits(addr[15:8], 8, rx);
            spi_bits(addr[7:0], 8, rx);
        end
        for (int k = 0; k < n; k++) begin
            spi_bits(8'($urandom), 8, rx);
            got.push_back(rx);
            chk({tag, " byte"}, rx, model_byte(op, addr, k));
        end
        ss_end();
        exp_reads = (op == 8'h03) ? n + 1 : 0;
        chk({tag, " reads"}, rd_log.size(), exp_reads);
        for (int k = 0; k < rd_log.size() && k < exp_reads; k++)
            chk({tag, " raddr"}, rd_log[k], ADDR_W'(addr + 24'(k)));
        chk({tag, " cmd_error"}, err_pulses, known ? 0 : 1);
        if (!known) chk({tag, " miso zero"}, miso_seen, 0);
    endtask

    initial begin
        logic [7:0]  rx;
        logic [7:0]  op;
        logic [23:0] addr;
        int          n;

        reset    = 1'b0;
        spi_sck  = 1'b0;
        spi_ss   = 1'b1;
        spi_mosi = 1'b0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) mem[i] = 8'(i);
        mem[MEM_SIZE-1] = 8'hAA;
        repeat (3) @(posedge clk);
        #3;
        chk("rst miso", spi_miso, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst rd_en", mem_rd_en, 0);
        chk("rst active", active, 0);
        chk("rst cmd_error", cmd_error, 0);
        reset = 1'b1;
        #(4 * HALF);

        // Plain read from address 0.
        run_txn("read0", 8'h03, 24'h000000, 5);
        for (int k = 0; k < 5 && k < got.size(); k++) chk("lit read0", got[k], 8'(k));

        // Wrap from the top of the 17-bit space to 0.
        mem[0] = 8'h55;
        run_txn("wrap", 8'h03, 24'h01FFFF, 2);
        if (got.size() == 2) begin
            chk("lit wrap0", got[0], 8'hAA);
            chk("lit wrap1", got[1], 8'h55);
        end else chk("lit wrap len", got.size(), 2);

        // JEDEC ID then zeros.
        run_txn("rdid", 8'h9F, 24'h0, 4);
        if (got.size() == 4) begin
            chk("lit id0", got[0], 8'hEF);
            chk("lit id1", got[1], 8'h40);
            chk("lit id2", got[2], 8'h17);
            chk("lit id3", got[3], 8'h00);
        end else chk("lit id len", got.size(), 4);

        run_txn("rdsr", 8'h05, 24'h0, 2);
        run_txn("badop", 8'hAB, 24'h0, 3);

        // Deselect after 12 address bits, then a clean read.
        ss_begin();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 4, rx);
        ss_end();
        chk("abort reads", rd_log.size(), 0);
        run_txn("after abort", 8'h03, 24'h000002, 1);
        if (got.size() == 1) chk("lit abort", got[0], 8'h02);

        // Reset in the middle of streaming data.
        ss_begin();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h10, 8, rx);
        spi_bits(8'h00, 8, rx);
        chk("pre-rst byte", rx, mem[16]);
        spi_bits(8'h00, 3, rx);
        txn_open = 1'b0;
        reset    = 1'b0;
        #1;
        chk("mid rst miso", spi_miso, 0);
        chk("mid rst mem_addr", mem_addr, 0);
        chk("mid rst rd_en", mem_rd_en, 0);
        chk("mid rst active", active, 0);
        chk("mid rst cmd_error", cmd_error, 0);
        #(HALF - 1);
        spi_sck = 1'b0;
        spi_ss  = 1'b1;
        #(4 * HALF);
        reset = 1'b1;
        #(4 * HALF);
        run_txn("post rst", 8'h03, 24'h000020, 3);

        // Random mix of commands, addresses and lengths.
        for (int t = 0; t < 20; t++) begin
            n    = $urandom_range(1, 6);
            addr = 24'($urandom);
            case ($urandom_range(0, 4))
                0, 1: begin
                    op = 8'h03;
                    if ($urandom_range(0, 2) == 0)
                        addr[16:0] = 17'h1FFFF - 17'($urandom_range(0, 3));
                end
                2: op = 8'h9F;
                3: op = 8'h05;
                default: begin
                    do op = 8'($urandom);
                    while (op == 8'h03 || op == 8'h9F || op == 8'h05);
                end
            endcase
            run_txn("rand", op, addr, n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
